// File: rtl/mouse_click_decoder_pkg.sv
// Shared types and widths for the mouse click decoder: FSM state encoding,
// index/position widths and the board-size clamp helper.
package mouse_pkg;

    localparam int CELL_IDX_W = 5;
    localparam int POS_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIVX,
        ST_DIVY,
        ST_VALID
    } state_t;

    function automatic logic [CELL_IDX_W-1:0] clamp_size(
        input logic [CELL_IDX_W-1:0] size,
        input logic [CELL_IDX_W-1:0] max_size
    );
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/mouse_click_decoder_if.sv
// Cell-event handshake between the click decoder (master) and the game FSM (slave).
interface mouse_click_decoder_if;
    import mouse_pkg::*;

    logic                  evt_valid;
    logic                  evt_ready;
    logic                  evt_left;
    logic                  evt_right;
    logic [CELL_IDX_W-1:0] cell_col;
    logic [CELL_IDX_W-1:0] cell_row;

    modport master (
        output evt_valid, evt_left, evt_right, cell_col, cell_row,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_left, evt_right, cell_col, cell_row,
        output evt_ready
    );

endinterface

// File: rtl/click_edge_detect.sv
// One button: registers the level and flags a rising edge. RST_VAL=1 keeps a
// button held through reset from reporting a press until re-pressed.
module click_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= RST_VAL;
        else     level_q <= level;
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/mouse_click_decoder.sv
// Turns button presses plus pointer position into one (col,row) cell event.
// Optional build macro: MOUSE_CLICK_HOLDOFF_EN adds a post-event press holdoff.
module mouse_click_decoder
    import mouse_pkg::*;
#(
    parameter logic [POS_W-1:0] BOARD_X   = 12'd192,
    parameter logic [POS_W-1:0] BOARD_Y   = 12'd96,
    parameter logic [POS_W-1:0] CELL_SIZE = 12'd32,
    parameter int unsigned      MAX_BOARD = 16
`ifdef MOUSE_CLICK_HOLDOFF_EN
   ,parameter logic [15:0]      HOLDOFF_CYCLES = 16'd65000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   left,
    input  logic                   right,
    input  logic [POS_W-1:0]       mouse_xpos,
    input  logic [POS_W-1:0]       mouse_ypos,
    input  logic [CELL_IDX_W-1:0]  board_size,
    output logic                   busy,
    mouse_click_decoder_if.master  evt
);

    localparam logic [CELL_IDX_W-1:0] MAX_SZ = CELL_IDX_W'(MAX_BOARD);

    // bit 0 = left, bit 1 = right
    logic [1:0] btn_level;
    logic [1:0] press;
    logic       take;

    assign btn_level = {right, left};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        click_edge_detect #(.RST_VAL(1'b1)) u_edge (
            .clk   (clk),
            .rst   (rst),
            .level (btn_level[b]),
            .press (press[b])
        );
    end

    state_t                state;
    logic [POS_W-1:0]      pos_x, pos_y;
    logic [POS_W-1:0]      remx, remy;
    logic [CELL_IDX_W-1:0] col, row, eff_size;
    logic [CELL_IDX_W-1:0] col_inc, row_inc;

    assign col_inc = col + 1'b1;
    assign row_inc = row + 1'b1;

`ifdef MOUSE_CLICK_HOLDOFF_EN
    logic [15:0] hold_cnt;

    // Contact-bounce window restarts on every accepted event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (state == ST_VALID && evt.evt_ready)
            hold_cnt <= HOLDOFF_CYCLES;
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 16'd1;
    end

    assign take = (|press) && (hold_cnt == '0);
`else
    assign take = |press;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            pos_x         <= '0;
            pos_y         <= '0;
            remx          <= '0;
            remy          <= '0;
            col           <= '0;
            row           <= '0;
            eff_size      <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_left  <= 1'b0;
            evt.evt_right <= 1'b0;
            evt.cell_col  <= '0;
            evt.cell_row  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        pos_x         <= mouse_xpos;
                        pos_y         <= mouse_ypos;
                        evt.evt_left  <= press[0];
                        evt.evt_right <= press[1];
                        eff_size      <= clamp_size(board_size, MAX_SZ);
                        state         <= ST_CHECK;
                        busy          <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (pos_x < BOARD_X || pos_y < BOARD_Y || eff_size == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        remx  <= pos_x - BOARD_X;
                        remy  <= pos_y - BOARD_Y;
                        col   <= '0;
                        row   <= '0;
                        state <= ST_DIVX;
                    end
                end
                ST_DIVX: begin
                    if (remx >= CELL_SIZE) begin
                        // Past the last column: pointer is right of the board.
                        if (col_inc == eff_size) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            remx <= remx - CELL_SIZE;
                            col  <= col_inc;
                        end
                    end else begin
                        state <= ST_DIVY;
                    end
                end
                ST_DIVY: begin
                    if (remy >= CELL_SIZE) begin
                        if (row_inc == eff_size) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            remy <= remy - CELL_SIZE;
                            row  <= row_inc;
                        end
                    end else begin
                        evt.cell_col  <= col;
                        evt.cell_row  <= row;
                        evt.evt_valid <= 1'b1;
                        state         <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (evt.evt_ready) begin
                        evt.evt_valid <= 1'b0;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    evt.evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_click_decoder.sv
// Directed bench for mouse_click_decoder: hits, chord, misses, busy drop,
// async reset, clamp, single-cycle handshake and (with the macro) holdoff.
module tb_mouse_click_decoder;
    import mouse_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  left = 1'b0;
    logic                  right = 1'b0;
    logic [POS_W-1:0]      mouse_xpos = '0;
    logic [POS_W-1:0]      mouse_ypos = '0;
    logic [CELL_IDX_W-1:0] board_size = '0;
    logic                  busy;

    int n_chk = 0;
    int n_err = 0;

    mouse_click_decoder_if evt_if ();

    mouse_click_decoder #(
        .BOARD_X   (12'd192),
        .BOARD_Y   (12'd96),
        .CELL_SIZE (12'd32),
        .MAX_BOARD (16)
`ifdef MOUSE_CLICK_HOLDOFF_EN
       ,.HOLDOFF_CYCLES (16'd20)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .board_size (board_size),
        .busy       (busy),
        .evt        (evt_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle press; returns after the sampling edge k.
    task automatic press(input logic l, input logic r, input int x, input int y,
                         input int bs);
        mouse_xpos = POS_W'(x);
        mouse_ypos = POS_W'(y);
        board_size = CELL_IDX_W'(bs);
        left  = l;
        right = r;
        tick();
        left  = 1'b0;
        right = 1'b0;
    endtask

    // Edges after k until evt_valid is seen; `limit` if it never rises.
    task automatic wait_valid(input int limit, output int lat);
        lat = 0;
        while (!evt_if.evt_valid && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic expect_miss(input string tag, input int x, input int y, input int bs);
        int lat;
        press(1'b1, 1'b0, x, y, bs);
        wait_valid(40, lat);
        chk(tag, int'(evt_if.evt_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int lat;
        int cnt;
        evt_if.evt_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_col",   int'(evt_if.cell_col), 0);
        chk("rst_left",  int'(evt_if.evt_left), 0);
        rst = 1'b0;
        tick();
        tick();

        // Left hit: 261 -> col 2, 223 -> row 3, latency 3+2+3
        press(1'b1, 1'b0, 261, 223, 8);
        chk("hit_busy", int'(busy), 1);
        wait_valid(40, lat);
        chk("hit_lat",   lat, 8);
        chk("hit_col",   int'(evt_if.cell_col), 2);
        chk("hit_row",   int'(evt_if.cell_row), 3);
        chk("hit_left",  int'(evt_if.evt_left), 1);
        chk("hit_right", int'(evt_if.evt_right), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (evt_if.evt_valid && evt_if.cell_col == 5'd2 && evt_if.cell_row == 5'd3 &&
                evt_if.evt_left && !evt_if.evt_right)
                cnt++;
        end
        chk("hit_hold", cnt, 5);
        accept();
        chk("hit_done_valid", int'(evt_if.evt_valid), 0);
        chk("hit_done_busy",  int'(busy), 0);

        // Chord at board origin
        press(1'b1, 1'b1, 192, 96, 8);
        wait_valid(40, lat);
        chk("chord_lat",   lat, 3);
        chk("chord_col",   int'(evt_if.cell_col), 0);
        chk("chord_row",   int'(evt_if.cell_row), 0);
        chk("chord_left",  int'(evt_if.evt_left), 1);
        chk("chord_right", int'(evt_if.evt_right), 1);
        accept();
        tick();
        tick();

        // Right only
        press(1'b0, 1'b1, 200, 100, 4);
        wait_valid(40, lat);
        chk("right_lat",   lat, 3);
        chk("right_left",  int'(evt_if.evt_left), 0);
        chk("right_right", int'(evt_if.evt_right), 1);
        accept();

        // Misses
        expect_miss("miss_x191", 191, 200, 8);
        expect_miss("miss_x448", 448, 200, 8);
        expect_miss("miss_bs0",  200, 200, 0);

        // Second press during DIVX is dropped
        press(1'b1, 1'b0, 261, 223, 8);
        tick();                 // edge k+1: CHECK
        left = 1'b1;
        tick();                 // edge k+2: DIVX, press ignored
        left = 1'b0;
        wait_valid(40, lat);
        chk("drop_valid", int'(evt_if.evt_valid), 1);
        chk("drop_col",   int'(evt_if.cell_col), 2);
        accept();
        wait_valid(30, lat);
        chk("drop_second", int'(evt_if.evt_valid), 0);

        // Reset while VALID clears evt_valid without waiting for an edge
        press(1'b1, 1'b0, 192, 96, 8);
        wait_valid(40, lat);
        chk("rv_pre", int'(evt_if.evt_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rv_valid", int'(evt_if.evt_valid), 0);
        chk("rv_busy",  int'(busy), 0);
        left = 1'b1;            // held through reset release
        tick();
        rst = 1'b0;
        wait_valid(20, lat);
        chk("held_rst", int'(evt_if.evt_valid), 0);
        left = 1'b0;
        tick();

        // Clamp: board_size 31 -> 16 cells
        press(1'b1, 1'b0, 192 + 15*32, 96, 31);
        wait_valid(40, lat);
        chk("clamp_lat", lat, 18);
        chk("clamp_col", int'(evt_if.cell_col), 15);
        accept();
        expect_miss("clamp_miss", 192 + 16*32, 96, 31);

        // Ready tied high: single-cycle valid
        evt_if.evt_ready = 1'b1;
        press(1'b1, 1'b0, 230, 140, 8);
        wait_valid(40, lat);
        cnt = 0;
        while (evt_if.evt_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("rdy_pulse", cnt, 1);
        evt_if.evt_ready = 1'b0;

`ifdef MOUSE_CLICK_HOLDOFF_EN
        // Handshake edge was the last tick; press at +10 ignored, at +25 taken.
        for (int i = 0; i < 9; i++) tick();
        press(1'b1, 1'b0, 192, 96, 8);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (evt_if.evt_valid) cnt++;
        end
        chk("hold_ignored", cnt, 0);
        press(1'b1, 1'b0, 192, 96, 8);
        wait_valid(40, lat);
        chk("hold_taken", lat, 3);
        accept();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
